johnson_rx: RTL and testbench

- Receiver/checker for Johnson-coded state words produced by the team's Johnson counters, e.g. a counter sampled across a block boundary.
- Decodes each sampled code to a binary index (0..2N-1) and flags illegal codes.
- Tracks the expected sequence and declares lock after a run of consecutive legal steps.
- Counts sequence errors while locked; intended as the consumer end of a Johnson-coded phase/position bus.

---
 rtl/johnson_pkg.sv | 44 ++++
 rtl/johnson_decode.sv | 24 ++
 rtl/johnson_rx.sv | 134 +++++++++++++
 tb/tb_johnson_rx.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/johnson_pkg.sv
// Shared types and width-generic helpers for Johnson-coded state words.
// Helpers take codes zero-extended to MAX_W bits plus the real code width.
package johnson_pkg;

  localparam int ERR_CNT_W = 8;
  localparam int MAX_W     = 32;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    CHECK  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  // Legal means at most one 0/1 transition across adjacent bits, ignoring the wrap.
  function automatic logic johnson_legal(input logic [MAX_W-1:0] c, input int w);
    int trans;
    trans = 0;
    for (int i = 1; i < MAX_W; i++) begin
      if (i < w && c[i] != c[i-1]) trans++;
    end
    return (trans <= 1);
  endfunction

  function automatic logic [MAX_W-1:0] johnson_succ(input logic [MAX_W-1:0] c, input int w);
    logic [MAX_W-1:0] s;
    s = '0;
    for (int i = 1; i < MAX_W; i++) begin
      if (i < w) s[i] = c[i-1];
    end
    s[0] = ~c[w-1];
    return s;
  endfunction

  function automatic int johnson_index(input logic [MAX_W-1:0] c, input int w);
    int ones;
    ones = 0;
    for (int i = 0; i < MAX_W; i++) begin
      if (i < w && c[i]) ones++;
    end
    if (c[0] || ones == 0) return ones;
    return w + (w - ones);
  endfunction

endpackage

// File: rtl/johnson_decode.sv
// Combinational Johnson decoder: legality, binary position and successor code.
module johnson_decode
  import johnson_pkg::*;
#(
  parameter  int N  = 4,
  localparam int IW = $clog2(2*N)
) (
  input  logic [N-1:0]  code,
  output logic          legal,
  output logic [IW-1:0] index,
  output logic [N-1:0]  succ
);

  logic [MAX_W-1:0] w_code_ext;

  assign w_code_ext = MAX_W'(code);

  always_comb begin
    legal = johnson_legal(w_code_ext, N);
    index = IW'(johnson_index(w_code_ext, N));
    succ  = N'(johnson_succ(w_code_ext, N));
  end

endmodule

// File: rtl/johnson_rx.sv
// Johnson-code receiver: decodes samples, hunts for sequence lock and
// counts sequence errors seen while locked.
module johnson_rx
  import johnson_pkg::*;
#(
  parameter  int N        = 4,
  parameter  int LOCK_CNT = 4,
  localparam int IW       = $clog2(2*N)
) (
  input  logic                 clk,
  input  logic                 arst_n,
  input  logic                 en,
  input  logic [N-1:0]         code,
  output logic [IW-1:0]        index,
  output logic                 valid,
  output logic                 locked,
  output logic                 err,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam int CW = $clog2(LOCK_CNT + 1);

  state_t               r_state, w_state_n;
  logic [N-1:0]         r_prev, w_prev_n;
  logic [N-1:0]         r_prev_succ, w_prev_succ_n;
  logic [CW-1:0]        r_good, w_good_n, w_good_inc;
  logic [IW-1:0]        r_index, w_index_n;
  logic                 r_valid, w_valid_n;
  logic                 r_locked;
  logic                 r_err, w_err_n;
  logic [ERR_CNT_W-1:0] r_err_cnt, w_err_cnt_n;

  logic                 w_legal;
  logic [IW-1:0]        w_idx;
  logic [N-1:0]         w_succ;
  logic                 w_is_succ, w_is_hold;

  johnson_decode #(.N(N)) u_decode (
    .code  (code),
    .legal (w_legal),
    .index (w_idx),
    .succ  (w_succ)
  );

  // Successor of the last legal code is kept registered so the step test is a plain compare.
  assign w_is_succ  = (code == r_prev_succ);
  assign w_is_hold  = (code == r_prev);
  assign w_good_inc = r_good + 1'b1;

  always_comb begin
    w_state_n     = r_state;
    w_good_n      = r_good;
    w_prev_n      = r_prev;
    w_prev_succ_n = r_prev_succ;
    w_index_n     = r_index;
    w_valid_n     = r_valid;
    w_err_n       = 1'b0;
    w_err_cnt_n   = r_err_cnt;
    if (en) begin
      w_valid_n = w_legal;
      if (w_legal) begin
        w_index_n     = w_idx;
        w_prev_n      = code;
        w_prev_succ_n = w_succ;
      end
      case (r_state)
        HUNT: begin
          if (w_legal) begin
            w_state_n = CHECK;
            w_good_n  = '0;
          end
        end
        CHECK: begin
          if (!w_legal) begin
            w_state_n = HUNT;
            w_good_n  = '0;
          end else if (w_is_succ) begin
            if (w_good_inc == CW'(LOCK_CNT)) begin
              w_state_n = LOCKED;
              w_good_n  = '0;
            end else begin
              w_good_n = w_good_inc;
            end
          end else if (!w_is_hold) begin
            w_good_n = '0;
          end
        end
        LOCKED: begin
          if (!w_legal || !(w_is_succ || w_is_hold)) begin
            w_err_n     = 1'b1;
            w_err_cnt_n = (r_err_cnt == '1) ? r_err_cnt : r_err_cnt + 1'b1;
            w_state_n   = w_legal ? CHECK : HUNT;
            w_good_n    = '0;
          end
        end
        default: begin
          w_state_n = HUNT;
          w_good_n  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_state     <= HUNT;
      r_prev      <= '0;
      r_prev_succ <= N'(1);
      r_good      <= '0;
      r_index     <= '0;
      r_valid     <= 1'b0;
      r_locked    <= 1'b0;
      r_err       <= 1'b0;
      r_err_cnt   <= '0;
    end else begin
      r_state     <= w_state_n;
      r_prev      <= w_prev_n;
      r_prev_succ <= w_prev_succ_n;
      r_good      <= w_good_n;
      r_index     <= w_index_n;
      r_valid     <= w_valid_n;
      r_locked    <= (w_state_n == LOCKED);
      r_err       <= w_err_n;
      r_err_cnt   <= w_err_cnt_n;
    end
  end

  assign index   = r_index;
  assign valid   = r_valid;
  assign locked  = r_locked;
  assign err     = r_err;
  assign err_cnt = r_err_cnt;

endmodule

// File: tb/tb_johnson_rx.sv
// Directed testbench for johnson_rx with N=4, LOCK_CNT=4.
module tb_johnson_rx;

  logic       clk;
  logic       arst_n;
  logic       en;
  logic [3:0] code;
  logic [2:0] index;
  logic       valid;
  logic       locked;
  logic       err;
  logic [7:0] err_cnt;

  int errors;
  int checks;

  johnson_rx #(.N(4), .LOCK_CNT(4)) dut (
    .clk     (clk),
    .arst_n  (arst_n),
    .en      (en),
    .code    (code),
    .index   (index),
    .valid   (valid),
    .locked  (locked),
    .err     (err),
    .err_cnt (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply one sample at the falling edge; outputs are observed 1ns after the next rising edge.
  task automatic drive(input logic [3:0] c, input logic e);
    @(negedge clk);
    code = c;
    en   = e;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    en = 1'b0;
    #2 arst_n = 1'b0;
    @(negedge clk);
    arst_n = 1'b1;
  endtask

  // From reset: 1110 enters CHECK, four successors reach LOCKED at 0001.
  task automatic lock_at_0001();
    drive(4'b1110, 1'b1);
    drive(4'b1100, 1'b1);
    drive(4'b1000, 1'b1);
    drive(4'b0000, 1'b1);
    drive(4'b0001, 1'b1);
  endtask

  task automatic test_reset();
    arst_n = 1'b0;
    en     = 1'b0;
    code   = 4'b0000;
    #12;
    checks++;
    if ({index, valid, locked, err, err_cnt} !== 14'h0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 0", {index, valid, locked, err, err_cnt});
    end
    @(negedge clk);
    arst_n = 1'b1;
  endtask

  task automatic test_lock_sequence();
    logic [3:0] seq [9] = '{4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111,
                            4'b1110, 4'b1100, 4'b1000, 4'b0000};
    logic [2:0] exp_idx [9] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};
    for (int i = 0; i < 9; i++) begin
      drive(seq[i], 1'b1);
      checks++;
      if (index !== exp_idx[i]) begin
        errors++;
        $display("FAIL seq_index[%0d]: got %0d expected %0d", i, index, exp_idx[i]);
      end
      checks++;
      if (valid !== 1'b1) begin
        errors++;
        $display("FAIL seq_valid[%0d]: got %b expected 1", i, valid);
      end
      checks++;
      if (locked !== (i >= 4)) begin
        errors++;
        $display("FAIL seq_locked[%0d]: got %b expected %b", i, locked, (i >= 4));
      end
      checks++;
      if (err !== 1'b0) begin
        errors++;
        $display("FAIL seq_err[%0d]: got %b expected 0", i, err);
      end
    end
  endtask

  task automatic test_hold();
    drive(4'b0001, 1'b1);
    drive(4'b0011, 1'b1);
    for (int k = 0; k < 5; k++) begin
      drive(4'b0011, 1'b1);
      checks++;
      if ({index, valid, locked, err, err_cnt} !== {3'd2, 1'b1, 1'b1, 1'b0, 8'd0}) begin
        errors++;
        $display("FAIL hold_en1[%0d]: got idx=%0d v=%b l=%b e=%b cnt=%0d expected idx=2 v=1 l=1 e=0 cnt=0",
                 k, index, valid, locked, err, err_cnt);
      end
      drive(4'b0101, 1'b0);
      checks++;
      if ({index, valid, locked, err, err_cnt} !== {3'd2, 1'b1, 1'b1, 1'b0, 8'd0}) begin
        errors++;
        $display("FAIL hold_en0[%0d]: got idx=%0d v=%b l=%b e=%b cnt=%0d expected idx=2 v=1 l=1 e=0 cnt=0",
                 k, index, valid, locked, err, err_cnt);
      end
    end
  endtask

  task automatic test_illegal_err();
    do_reset();
    lock_at_0001();
    checks++;
    if (locked !== 1'b1 || index !== 3'd1) begin
      errors++;
      $display("FAIL ill_prelock: got l=%b idx=%0d expected l=1 idx=1", locked, index);
    end
    drive(4'b0101, 1'b1);
    checks++;
    if ({err, err_cnt, valid, locked, index} !== {1'b1, 8'd1, 1'b0, 1'b0, 3'd1}) begin
      errors++;
      $display("FAIL ill_err: got e=%b cnt=%0d v=%b l=%b idx=%0d expected e=1 cnt=1 v=0 l=0 idx=1",
               err, err_cnt, valid, locked, index);
    end
    drive(4'b0000, 1'b1);
    checks++;
    if ({err, err_cnt, valid, locked, index} !== {1'b0, 8'd1, 1'b1, 1'b0, 3'd0}) begin
      errors++;
      $display("FAIL ill_recover: got e=%b cnt=%0d v=%b l=%b idx=%0d expected e=0 cnt=1 v=1 l=0 idx=0",
               err, err_cnt, valid, locked, index);
    end
  endtask

  task automatic test_skip_err();
    logic [3:0] seq [4] = '{4'b1111, 4'b1110, 4'b1100, 4'b1000};
    do_reset();
    lock_at_0001();
    drive(4'b0111, 1'b1);
    checks++;
    if ({err, err_cnt, valid, locked, index} !== {1'b1, 8'd1, 1'b1, 1'b0, 3'd3}) begin
      errors++;
      $display("FAIL skip_err: got e=%b cnt=%0d v=%b l=%b idx=%0d expected e=1 cnt=1 v=1 l=0 idx=3",
               err, err_cnt, valid, locked, index);
    end
    for (int i = 0; i < 4; i++) begin
      drive(seq[i], 1'b1);
      checks++;
      if (locked !== (i == 3) || err !== 1'b0) begin
        errors++;
        $display("FAIL skip_relock[%0d]: got l=%b e=%b expected l=%b e=0", i, locked, err, (i == 3));
      end
    end
  endtask

  task automatic test_async_reset();
    logic [3:0] seq [4] = '{4'b0111, 4'b1111, 4'b1110, 4'b1100};
    @(posedge clk);
    #3 arst_n = 1'b0;
    #1;
    checks++;
    if ({index, valid, locked, err, err_cnt} !== 14'h0) begin
      errors++;
      $display("FAIL async_reset: got %h expected 0", {index, valid, locked, err, err_cnt});
    end
    @(negedge clk);
    en     = 1'b0;
    arst_n = 1'b1;
    drive(4'b0011, 1'b1);
    checks++;
    if ({index, valid, locked} !== {3'd2, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL async_first: got idx=%0d v=%b l=%b expected idx=2 v=1 l=0", index, valid, locked);
    end
    for (int i = 0; i < 4; i++) begin
      drive(seq[i], 1'b1);
      checks++;
      if (locked !== (i == 3)) begin
        errors++;
        $display("FAIL async_relock[%0d]: got %b expected %b", i, locked, (i == 3));
      end
    end
  endtask

  task automatic test_saturation();
    int exp_cnt;
    do_reset();
    for (int k = 0; k < 300; k++) begin
      drive(4'b0000, 1'b1);
      drive(4'b0001, 1'b1);
      drive(4'b0011, 1'b1);
      drive(4'b0111, 1'b1);
      drive(4'b1111, 1'b1);
      checks++;
      if (locked !== 1'b1) begin
        errors++;
        $display("FAIL sat_lock[%0d]: got %b expected 1", k, locked);
      end
      drive(4'b0101, 1'b1);
      exp_cnt = (k + 1 > 255) ? 255 : k + 1;
      checks++;
      if (err !== 1'b1) begin
        errors++;
        $display("FAIL sat_err[%0d]: got %b expected 1", k, err);
      end
      checks++;
      if (err_cnt !== 8'(exp_cnt)) begin
        errors++;
        $display("FAIL sat_cnt[%0d]: got %0d expected %0d", k, err_cnt, exp_cnt);
      end
    end
    drive(4'b0000, 1'b1);
    checks++;
    if (err_cnt !== 8'd255 || err !== 1'b0) begin
      errors++;
      $display("FAIL sat_final: got cnt=%0d e=%b expected cnt=255 e=0", err_cnt, err);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_lock_sequence();
    test_hold();
    test_illegal_err();
    test_skip_err();
    test_async_reset();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
